// File: rtl/wb_pkg.sv
// Shared types and source-index constants for the write-back stage.
package wb_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    ESPERA_ES = 1'b1
  } wb_state_t;

  localparam int SRC_ULA = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_ES  = 3;

endpackage

// File: rtl/wb_mux_n.sv
// N-way result selector; any selector value with no matching source falls back to source 0.
module wb_mux_n #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 4,
  parameter int SEL_W  = $clog2(N_SRC)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_SRC*DATA_W-1:0] src,
  output logic [DATA_W-1:0]       y
);

  // NOTE: y gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    y = src[DATA_W-1:0];
    for (int i = 1; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) y = src[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/estagio_write_back.sv
// Registered write-back stage with I/O request/valid handshake and pipeline stall.
// Optional I/O wait timeout is enabled by defining WB_TIMEOUT_EN.
module estagio_write_back
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_SRC       = 4,
  parameter int SEL_W       = $clog2(N_SRC),
  parameter int ADDR_W      = 5,
  parameter int IO_SRC      = SRC_ES,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Valid_In,
  input  logic [SEL_W-1:0]        Seletor,
  input  logic [N_SRC*DATA_W-1:0] Fontes,
  input  logic                    Escreve_Reg_In,
  input  logic [ADDR_W-1:0]       End_Reg_In,
  input  logic                    ES_Valido,
  output logic                    ES_Req,
  output logic                    Stall,
  output logic [DATA_W-1:0]       W_Data,
  output logic [ADDR_W-1:0]       W_Addr,
  output logic                    W_En,
  output logic                    Erro_Timeout
);

  localparam logic [SEL_W-1:0] IO_SEL = SEL_W'(IO_SRC);

  wb_state_t          state, state_next;
  logic [DATA_W-1:0]  sel_data;
  logic [ADDR_W-1:0]  lat_addr;
  logic               lat_en;
  logic               timeout_hit;

  logic               wr, latch, req_next, wr_en_raw;
  logic [DATA_W-1:0]  wr_data;
  logic [ADDR_W-1:0]  wr_addr;

  wb_mux_n #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC),
    .SEL_W  (SEL_W)
  ) u_mux (
    .sel (Seletor),
    .src (Fontes),
    .y   (sel_data)
  );

  // Only a wait cycle without valid data freezes upstream; reset forces IDLE so this drops at once.
  assign Stall = (state == ESPERA_ES) && !ES_Valido;

  always_comb begin
    state_next = state;
    wr         = 1'b0;
    latch      = 1'b0;
    req_next   = ES_Req;
    wr_data    = sel_data;
    wr_addr    = End_Reg_In;
    wr_en_raw  = Escreve_Reg_In;
    case (state)
      IDLE: begin
        if (Valid_In) begin
          if (Seletor == IO_SEL) begin
            state_next = ESPERA_ES;
            latch      = 1'b1;
            req_next   = 1'b1;
          end else begin
            wr = 1'b1;
          end
        end
      end
      ESPERA_ES: begin
        wr_addr   = lat_addr;
        wr_en_raw = lat_en;
        // Valid data takes priority over a timeout landing on the same cycle.
        if (ES_Valido) begin
          wr         = 1'b1;
          wr_data    = Fontes[IO_SRC*DATA_W +: DATA_W];
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (timeout_hit) begin
          wr         = 1'b1;
          wr_data    = '0;
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      ES_Req   <= 1'b0;
      W_Data   <= '0;
      W_Addr   <= '0;
      W_En     <= 1'b0;
      lat_addr <= '0;
      lat_en   <= 1'b0;
    end else begin
      state  <= state_next;
      ES_Req <= req_next;
      W_En   <= wr && wr_en_raw && (wr_addr != '0);
      if (wr) begin
        W_Data <= wr_data;
        W_Addr <= wr_addr;
      end
      if (latch) begin
        lat_addr <= End_Reg_In;
        lat_en   <= Escreve_Reg_In;
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside the wait state, so it starts from zero on every entry.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= '0;
    end else if (state != ESPERA_ES) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ESPERA_ES) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Erro_Timeout <= 1'b0;
    end else if (timeout_hit && !ES_Valido) begin
      Erro_Timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign Erro_Timeout = 1'b0;
`endif

endmodule
